btn_select_ctrl: RTL
====================

// Module: btn_select_ctrl
// PURPOSE
//  Conditions the raw push-button that chooses which value the 7-segment display shows:
//  2-FF sync, counter debounce, press FSM, toggle register.
//  Its `sel` output drives the display multiplexer select (0 = corrected data, 1 = syndrome).
//  One press flips the display and the selection persists; holding is no longer needed.
// PARAMETERS
//  DEBOUNCE_CYCLES    270_000     consecutive stable cycles to accept an edge (10 ms @ 27 MHz)
//  SEL_RESET          1'b0        sel value after reset (0 = data view)
//  LONG_PRESS_CYCLES  27_000_000  hold time that toggles auto-scan (AUTO_SCAN_EN only)
//  SCAN_CYCLES        27_000_000  auto-scan sel period, half-cycle (AUTO_SCAN_EN only)
// PORTS
//  clk          in   1  system clock, single domain
//  rst_n        in   1  asynchronous active-low reset
//  btn_raw      in   1  raw button pin, asynchronous, bouncy, active-high
//  btn_level    out  1  debounced button level
//  press_pulse  out  1  one-cycle strobe per accepted press
//  sel          out  1  display select to the display multiplexer
//  auto_mode    out  1  auto-scan active; tied 0 without AUTO_SCAN_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): btn_level=0, press_pulse=0, sel=SEL_RESET, auto_mode=0.
//    Reset also clears the FSM (to IDLE), all counters and the sync flops. All outputs are registered.
//  - Sync: 2 flops; `s` = second flop. The debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
//  - FSM states: IDLE, PRESS_CNT, HELD, RELEASE_CNT.
//    IDLE -> PRESS_CNT when s=1; counter cleared.
//    PRESS_CNT: s=1 increments the counter; s=0 clears it and returns to IDLE (glitch rejected).
//      When the counter reaches DEBOUNCE_CYCLES-1 with s=1: go to HELD.
//      On that same edge: btn_level<=1, press_pulse<=1, sel<=~sel (sel toggles only if auto_mode=0).
//    HELD -> RELEASE_CNT when s=0. Mirror of the press path on release:
//      s=1 returns to HELD; counter reaching DEBOUNCE_CYCLES-1 goes to IDLE with btn_level<=0.
//      There is no pulse on release.
//  - Latency: the outputs update on edge DEBOUNCE_CYCLES+2, counting the first edge that samples btn_raw=1.
//    The release path has the same latency.
//  - press_pulse is high for exactly 1 cycle per press, independent of hold length.
//  - A bounce shorter than DEBOUNCE_CYCLES never changes any output.
//  - Counters saturate and never wrap.
//  - Reset mid-press discards the press entirely. A button still held at reset release needs a full debounce.
// CONFIGURATION
//  Macro AUTO_SCAN_EN:
//  - Defined: in HELD, a hold counter runs. On reaching LONG_PRESS_CYCLES it toggles auto_mode
//    (once per press; the counter saturates).
//    While auto_mode=1, sel inverts every SCAN_CYCLES. The scan counter clears on auto_mode entry.
//    In auto mode, short presses still pulse but do not toggle sel. Leaving auto mode keeps the current sel.
//    The press that starts a long hold has already toggled sel at debounce time.
//  - Undefined: no hold/scan counters exist; auto_mode is constant 0; sel changes only on presses.
// STRUCTURE
//  - Shared package hamming_disp_pkg:
//    btn_state_t enum {IDLE, PRESS_CNT, HELD, RELEASE_CNT};
//    SEL_DATA=1'b0; SEL_SIND=1'b1 (shared with the display multiplexer).
//  - Sub-module sync_2ff (generic 2-flop synchronizer, async active-low reset to 0).
//  - FSM, counters and optional scan logic stay in this module.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, SCAN_CYCLES=8)
//  1 Reset: rst_n=0 with btn_raw toggling -> all outputs at reset values.
//    After release with btn_raw=0 for 50 cycles -> no change.
//  2 Clean press: btn_raw 0->1 held 10 cycles -> btn_level=1 and sel 0->1 on edge 6.
//    press_pulse high for exactly that cycle.
//    Release -> btn_level=0 on 6th edge after release; sel stays 1.
//  3 Bounce: btn_raw 1 for 3 cycles, 0 for 2, repeated 5 times -> no output change.
//    Then held 1 -> single pulse, sel toggles once.
//  4 Three separated presses -> sel sequence 1,0,1; exactly 3 pulses.
//  5 Reset mid-press: assert rst_n=0 during PRESS_CNT -> outputs reset.
//    Button kept high after release -> press accepted 6 edges after the first sampling edge.
//  6 AUTO_SCAN_EN: hold 30 cycles -> auto_mode=1, then sel inverts every 8 cycles.
//    Short press -> pulse, no sel toggle.
//    Long press again -> auto_mode=0 and sel frozen.
//    Without the macro, the same stimulus gives auto_mode=0 throughout.

Source files
------------

// File: rtl/hamming_disp_pkg.sv
// Shared types and constants for the Hamming display path: button FSM states and display select codes.
package hamming_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    HELD,
    RELEASE_CNT
  } btn_state_t;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_SIND = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_select_ctrl.sv
// Push-button conditioner: sync, counter debounce, press FSM and sel toggle register.
// Optional macro AUTO_SCAN_EN adds long-press auto-scan of the display select.
module btn_select_ctrl
  import hamming_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 270_000,
  parameter logic        SEL_RESET         = SEL_DATA,
  parameter int unsigned LONG_PRESS_CYCLES = 27_000_000,
  parameter int unsigned SCAN_CYCLES       = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic sel,
  output logic auto_mode
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // The IDLE->PRESS_CNT edge is the first stable sample, so acceptance fires one count early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1 || SCAN_CYCLES < 1) begin : g_cfg_check
    $error("btn_select_ctrl: cycle parameters out of range");
  end

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic       s;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       pulse_q, pulse_d;
  logic       sel_q, sel_d;
  logic       press_acc;
  logic       auto_q;
  logic       scan_tick;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    press_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_CNT;
          cnt_d   = '0;
        end
      end
      PRESS_CNT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          level_d   = 1'b1;
          pulse_d   = 1'b1;
          press_acc = 1'b1;
        end else begin
          cnt_d = sat_inc_cnt(cnt_q);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_CNT;
          cnt_d   = '0;
        end
      end
      RELEASE_CNT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = sat_inc_cnt(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Presses only steer sel by hand while auto-scan is off; the scan owns it otherwise.
  always_comb begin
    sel_d = sel_q;
    if (press_acc && !auto_q) sel_d = ~sel_q;
    if (scan_tick)            sel_d = ~sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      sel_q   <= SEL_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      sel_q   <= sel_d;
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
  endfunction

  logic [HOLD_W-1:0] hold_q;
  logic [SCAN_W-1:0] scan_q;

  assign scan_tick = auto_q && (scan_q == SCAN_LAST);

  // Hold counter restarts on each accepted press and saturates, so auto_mode flips once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      scan_q <= '0;
      auto_q <= 1'b0;
    end else begin
      if (press_acc) begin
        hold_q <= '0;
      end else if (state_q == HELD) begin
        hold_q <= sat_inc_hold(hold_q);
        if (hold_q == HOLD_LAST) auto_q <= ~auto_q;
      end
      if (!auto_q || scan_tick) scan_q <= '0;
      else                      scan_q <= scan_q + SCAN_W'(1);
    end
  end
`else
  assign auto_q    = 1'b0;
  assign scan_tick = 1'b0;
`endif

  assign btn_level   = level_q;
  assign press_pulse = pulse_q;
  assign sel         = sel_q;
  assign auto_mode   = auto_q;

endmodule
